sdram_req_arbiter: RTL and testbench
====================================

# sdram_req_arbiter

Arbitrates two independent requesters (port 0, port 1) and a periodic auto-refresh timer for access to the single SDRAM controller core. Each transaction is issued as one command on a valid/ready interface and finished by the core's completion pulse. The block sits between the user-side masters and the SDRAM command sequencer. Only one transaction is ever outstanding.

## Interface
- ADDR_W, 24, address width
- DATA_W, 16, data width
- REFRESH_INTERVAL, 780, clk cycles between refresh requests (7.8 us at 100 MHz); must be ≥ 2
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req0 / req1  input  1  request; held high with fields stable until matching ack
- we0 / we1  input  1  1 = write, 0 = read
- addr0 / addr1  input  ADDR_W  request address
- wdata0 / wdata1  input  DATA_W  write data
- ack0 / ack1  output  1  one-cycle completion pulse
- rdata  output  DATA_W  read data; valid with ack, held until next read completes
- cmd_valid  output  1  command presented to core
- cmd_op  output  2  0 = read, 1 = write, 2 = refresh (3 unused)
- cmd_addr  output  ADDR_W  command address (0 for refresh)
- cmd_wdata  output  DATA_W  command write data (0 for refresh/read)
- cmd_ready  input  1  core accepts command when high with cmd_valid
- cmd_done  input  1  one-cycle pulse: accepted command finished
- cmd_rdata  input  DATA_W  read data, valid with cmd_done
- refresh_miss  output  1  sticky: a refresh interval elapsed while previous refresh still pending

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state IDLE.
- IDLE: evaluates in priority order: refresh_pending → ISSUE(refresh); else one or both reqN → ISSUE(selected port); else stay. Command fields registered on that transition.
- Round robin: rr_last register (reset 1). Both requesting → grant port ≠ rr_last; one requesting → grant it. rr_last updated to granted port on entry to ISSUE (not for refresh).
- ISSUE: cmd_valid = 1, fields constant. cmd_ready sampled high → WAIT.
- WAIT: cmd_valid = 0. cmd_done sampled high → DONE (refresh) or DONE with ackN set for granted port; on read, rdata ← cmd_rdata.
- DONE: ackN high for exactly this cycle (refresh: no ack); requests not sampled; → IDLE. Requester must drop reqN on the edge ending the ack cycle; reqN still high in the next IDLE is a new request.
- Refresh counter: free-running, 0 … REFRESH_INTERVAL-1, wraps; runs in every state. On wrap: refresh_pending ← 1; if already 1, refresh_miss ← 1 (cleared only by reset).
- refresh_pending cleared on refresh acceptance (ISSUE, op refresh, cmd_ready). Wrap in the same cycle as acceptance: pending stays 1 (new interval wins), no miss.
- cmd_done outside WAIT is ignored. reqN never preempts an issued command.

## Timing
- Reset (async, reset_n low): state IDLE, cmd_valid 0, cmd_op 0, cmd_addr 0, cmd_wdata 0, ack0/ack1 0, rdata 0, refresh counter 0, refresh_pending 0, refresh_miss 0, rr_last 1. Reset mid-transaction abandons it with no ack.
- Request sampled in IDLE at edge N → cmd_valid high from cycle N+1.
- cmd_ready high at edge M → cmd_valid low from M+1.
- cmd_done high at edge K → ackN and rdata valid in cycle K+1; IDLE at K+2; earliest next cmd_valid K+3.
- First refresh_pending assertion: REFRESH_INTERVAL cycles after reset release.

## Test plan
- Reset: drive reset_n low mid-ISSUE → all outputs at reset values immediately; after release, no ack, cmd_valid 0.
- Single read: req0=1, we0=0, addr0=0x001234; core ready immediately, cmd_done 3 cycles later with cmd_rdata=0xBEEF → cmd_op 0, cmd_addr 0x001234, one-cycle ack0, rdata 0xBEEF, ack1 never high.
- Contention: req0 and req1 (writes, wdata 0xAAAA / 0x5555) held continuously for four transactions → grants ordered 0,1,0,1; cmd_wdata matches granted port.
- Refresh priority: REFRESH_INTERVAL=16, req1 held high → at first wrap the next command from IDLE is cmd_op 2 with addr 0, no ack; req1 served immediately after.
- Refresh miss: REFRESH_INTERVAL=16, cmd_ready held 0 for 40 cycles → refresh_miss goes 1 at second wrap and stays 1 after refresh accepted.
- Backpressure/stray done: cmd_ready low for 5 cycles → cmd_valid and fields stable throughout; cmd_done pulsed during ISSUE ignored (no ack).

Source files
------------

// File: rtl/sdram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_req_arbiter
//
// Shares one SDRAM controller core between two user requesters and the
// periodic auto-refresh timer. Refresh has priority; the two user ports are
// served round robin. Exactly one command is in flight at a time. It is
// issued on a valid/ready handshake and retired by the core's cmd_done pulse.
//
// Ports
//   clk, reset_n          system clock (rising edge), async active-low reset
//   req0/req1             user requests, held with fields stable until ackN
//   we0/we1               1 = write, 0 = read
//   addr0/addr1           request address
//   wdata0/wdata1         write data
//   ack0/ack1             one-cycle completion pulse to the granted port
//   rdata                 last read data, valid with ack, held until next read
//   cmd_valid/cmd_ready   command handshake towards the core
//   cmd_op                0 = read, 1 = write, 2 = refresh
//   cmd_addr/cmd_wdata    command fields (zero where not meaningful)
//   cmd_done/cmd_rdata    completion pulse and read data from the core
//   refresh_miss          sticky: an interval ended with a refresh still pending
// ---------------------------------------------------------------------------
module sdram_req_arbiter #(
    parameter int ADDR_W           = 24,
    parameter int DATA_W           = 16,
    parameter int REFRESH_INTERVAL = 780
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              cmd_valid,
    output logic [1:0]        cmd_op,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_wdata,
    input  logic              cmd_ready,
    input  logic              cmd_done,
    input  logic [DATA_W-1:0] cmd_rdata,
    output logic              refresh_miss
);

    localparam int CNT_W = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] OP_READ    = 2'd0;
    localparam logic [1:0] OP_WRITE   = 2'd1;
    localparam logic [1:0] OP_REFRESH = 2'd2;

    logic [1:0]       state;
    logic             rr_last;      // last granted user port; doubles as the ack target
    logic [CNT_W-1:0] refresh_cnt;
    logic             refresh_pending;

    logic              grant;
    logic              grant_we;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;
    logic              wrap;
    logic              refresh_accept;

    // Round robin: under contention the port that was not served last wins.
    always_comb begin
        // NOTE: give every combinational output a default first so no path
        // leaves it unassigned and a latch is never inferred.
        grant = 1'b0;
        if (req0 && req1) begin
            grant = ~rr_last;
        end else if (req1) begin
            grant = 1'b1;
        end
    end

    assign grant_we    = grant ? we1    : we0;
    assign grant_addr  = grant ? addr1  : addr0;
    assign grant_wdata = grant ? wdata1 : wdata0;

    assign wrap           = (refresh_cnt == CNT_W'(REFRESH_INTERVAL - 1));
    assign refresh_accept = (state == ST_ISSUE) && (cmd_op == OP_REFRESH) && cmd_ready;

    // Free-running refresh timer. A wrap coinciding with acceptance starts a
    // new interval, so pending stays set and no miss is recorded.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refresh_cnt     <= '0;
            refresh_pending <= 1'b0;
            refresh_miss    <= 1'b0;
        end else begin
            refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
            if (wrap) begin
                refresh_pending <= 1'b1;
                if (refresh_pending && !refresh_accept) begin
                    refresh_miss <= 1'b1;
                end
            end else if (refresh_accept) begin
                refresh_pending <= 1'b0;
            end
        end
    end

    // Transaction sequencer. Command fields are captured on leaving IDLE and
    // held unchanged until the next transaction starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cmd_valid <= 1'b0;
            cmd_op    <= OP_READ;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata     <= '0;
            rr_last   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (refresh_pending) begin
                        state     <= ST_ISSUE;
                        cmd_valid <= 1'b1;
                        cmd_op    <= OP_REFRESH;
                        cmd_addr  <= '0;
                        cmd_wdata <= '0;
                    end else if (req0 || req1) begin
                        state     <= ST_ISSUE;
                        cmd_valid <= 1'b1;
                        cmd_op    <= grant_we ? OP_WRITE : OP_READ;
                        cmd_addr  <= grant_addr;
                        cmd_wdata <= grant_we ? grant_wdata : '0;
                        rr_last   <= grant;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cmd_done) begin
                        state <= ST_DONE;
                        if (cmd_op != OP_REFRESH) begin
                            ack0 <= ~rr_last;
                            ack1 <= rr_last;
                        end
                        if (cmd_op == OP_READ) begin
                            rdata <= cmd_rdata;
                        end
                    end
                end
                ST_DONE: begin
                    // Requests are deliberately not sampled here.
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_req_arbiter
//
// The bench plays both requesters and the SDRAM core. A transaction-level
// reference model predicts, per clock edge, which command the arbiter must
// issue, when it must be visible, which port is acknowledged, the read data
// returned and the refresh_miss flag. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_sdram_req_arbiter;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;
    localparam int RI     = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req0 = 1'b0, req1 = 1'b0;
    logic              we0 = 1'b0, we1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic              ack0, ack1;
    logic [DATA_W-1:0] rdata;
    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              cmd_ready = 1'b0;
    logic              cmd_done = 1'b0;
    logic [DATA_W-1:0] cmd_rdata = '0;
    logic              refresh_miss;

    sdram_req_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REFRESH_INTERVAL(RI)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_ready(cmd_ready), .cmd_done(cmd_done),
        .cmd_rdata(cmd_rdata), .refresh_miss(refresh_miss)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: edge counter since reset release and transaction plan.
    int              t;
    bit              m_pend, m_miss, m_rr;
    logic [DATA_W-1:0] m_rdata;
    bit              tx_on, tx_ref, tx_port;
    logic [1:0]      tx_op;
    logic [ADDR_W-1:0] tx_addr;
    logic [DATA_W-1:0] tx_wdata;
    int              tx_dec, tx_rdy, tx_done, next_dec;
    bit              exp_ack0, exp_ack1;

    // Stimulus knobs.
    int              k_req0, k_req1, k_stray;
    bit              k_hold, k_fix_rdata;
    int              kr_lo, kr_hi, kd_lo, kd_hi;
    logic [DATA_W-1:0] k_rdata;

    // Observations of the DUT, compared later against constants.
    int              q_grant[$];
    int              q_ops[$];
    bit              prev_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, expv, t);
        end
    endtask

    task automatic model_reset();
        t = 0; m_pend = 0; m_miss = 0; m_rr = 1; m_rdata = '0;
        tx_on = 0; tx_ref = 0; tx_port = 0; next_dec = 0;
        exp_ack0 = 0; exp_ack1 = 0; prev_valid = 0;
        q_grant.delete(); q_ops.delete();
    endtask

    // Applied once per rising edge, using the inputs that edge sampled.
    task automatic model_edge();
        bit pend_old;
        bit acc_ref;
        bit wrap;
        pend_old = m_pend;
        t++;
        exp_ack0 = 0;
        exp_ack1 = 0;
        acc_ref  = tx_on && tx_ref && (t == tx_rdy);
        wrap     = (t % RI) == 0;
        if (wrap && m_pend && !acc_ref) m_miss = 1;
        if (wrap) m_pend = 1;
        else if (acc_ref) m_pend = 0;

        if (tx_on && t == tx_done) begin
            if (!tx_ref) begin
                if (tx_port) exp_ack1 = 1; else exp_ack0 = 1;
                if (tx_op == 2'd0) m_rdata = cmd_rdata;
            end
            tx_on    = 0;
            next_dec = t + 2;
        end else if (!tx_on && t >= next_dec && (pend_old || req0 || req1)) begin
            if (pend_old) begin
                tx_ref = 1; tx_op = 2'd2; tx_addr = '0; tx_wdata = '0;
            end else begin
                tx_ref  = 0;
                tx_port = (req0 && req1) ? !m_rr : req1;
                m_rr    = tx_port;
                tx_op   = (tx_port ? we1 : we0) ? 2'd1 : 2'd0;
                tx_addr = tx_port ? addr1 : addr0;
                tx_wdata = (tx_op == 2'd1) ? (tx_port ? wdata1 : wdata0) : '0;
            end
            tx_on   = 1;
            tx_dec  = t;
            tx_rdy  = t + 1 + int'($urandom_range(kr_hi, kr_lo));
            tx_done = tx_rdy + 1 + int'($urandom_range(kd_hi, kd_lo));
        end
    endtask

    task automatic check_outputs();
        bit exp_valid;
        exp_valid = tx_on && (t >= tx_dec) && (t < tx_rdy);
        check("cmd_valid", cmd_valid, exp_valid);
        if (exp_valid) begin
            check("cmd_op", cmd_op, tx_op);
            check("cmd_addr", cmd_addr, tx_addr);
            check("cmd_wdata", cmd_wdata, tx_wdata);
        end
        check("ack0", ack0, exp_ack0);
        check("ack1", ack1, exp_ack1);
        check("rdata", rdata, m_rdata);
        check("refresh_miss", refresh_miss, m_miss);
        if (ack0 === 1'b1 || ack1 === 1'b1) q_grant.push_back(int'(ack1));
        if (cmd_valid === 1'b1 && !prev_valid) q_ops.push_back(int'(cmd_op));
        prev_valid = (cmd_valid === 1'b1);
    endtask

    // Drives inputs for the next edge; the core side obeys the plan.
    task automatic drive_inputs();
        int  e;
        bit  in_issue, in_wait;
        e = t + 1;
        in_issue = tx_on && (e > tx_dec) && (e <= tx_rdy);
        in_wait  = tx_on && (e > tx_rdy) && (e <= tx_done);
        cmd_ready = in_issue ? (e == tx_rdy)  : ($urandom_range(999, 0) < k_stray);
        cmd_done  = in_wait  ? (e == tx_done) : ($urandom_range(999, 0) < k_stray);
        cmd_rdata = k_fix_rdata ? k_rdata : DATA_W'($urandom);

        if (exp_ack0 && !k_hold) req0 = 0;
        if (exp_ack1 && !k_hold) req1 = 0;
        if (!req0 && $urandom_range(999, 0) < k_req0) begin
            req0 = 1; we0 = 1'($urandom); addr0 = ADDR_W'($urandom); wdata0 = DATA_W'($urandom);
        end
        if (!req1 && $urandom_range(999, 0) < k_req1) begin
            req1 = 1; we1 = 1'($urandom); addr1 = ADDR_W'($urandom); wdata1 = DATA_W'($urandom);
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs();
            drive_inputs();
        end
    endtask

    task automatic set_knobs(input int rlo, input int rhi, input int dlo, input int dhi,
                             input int rq0, input int rq1, input int stray, input bit hold);
        kr_lo = rlo; kr_hi = rhi; kd_lo = dlo; kd_hi = dhi;
        k_req0 = rq0; k_req1 = rq1; k_stray = stray; k_hold = hold;
        k_fix_rdata = 0;
    endtask

    // Asserts reset asynchronously, optionally checks the reset values right
    // away (no clock edge in between), then releases on a falling edge.
    task automatic do_reset(input bit chk);
        #1;
        reset_n = 0;
        req0 = 0; req1 = 0; cmd_ready = 0; cmd_done = 0;
        #1;
        if (chk) begin
            check("rst_cmd_valid", cmd_valid, 1'b0);
            check("rst_cmd_op", cmd_op, 2'd0);
            check("rst_cmd_addr", cmd_addr, '0);
            check("rst_cmd_wdata", cmd_wdata, '0);
            check("rst_ack0", ack0, 1'b0);
            check("rst_ack1", ack1, 1'b0);
            check("rst_rdata", rdata, '0);
            check("rst_refresh_miss", refresh_miss, 1'b0);
        end
        repeat (2) @(negedge clk);
        model_reset();
        reset_n = 1;
    endtask

    int exp_order[4] = '{0, 1, 0, 1};
    int idx;
    int budget;

    initial begin
        model_reset();
        set_knobs(0, 0, 0, 0, 0, 0, 0, 0);
        k_rdata = '0;

        // Power-on reset values.
        do_reset(1);

        // Single read from port 0: immediate ready, done three cycles later.
        set_knobs(0, 0, 2, 2, 0, 0, 0, 0);
        k_fix_rdata = 1;
        k_rdata     = 16'hBEEF;
        req0 = 1; we0 = 0; addr0 = 24'h001234; wdata0 = 16'h1111;
        run_cycles(10);
        check("read_rdata", rdata, 16'hBEEF);
        check("read_ack_count", q_grant.size(), 1);
        if (q_grant.size() > 0) check("read_ack_port", q_grant[0], 0);

        // Contention: both ports write continuously, grants must alternate.
        do_reset(0);
        set_knobs(0, 2, 0, 2, 0, 0, 0, 1);
        we0 = 1; we1 = 1; wdata0 = 16'hAAAA; wdata1 = 16'h5555;
        addr0 = 24'h00A0A0; addr1 = 24'h050505;
        req0 = 1; req1 = 1;
        budget = 80;
        while (q_grant.size() < 4 && budget > 0) begin
            run_cycles(1);
            budget--;
        end
        check("contention_count_ok", q_grant.size() >= 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i < q_grant.size()) check("grant_order", q_grant[i], exp_order[i]);
        end

        // Refresh priority with port 1 continuously requesting.
        do_reset(0);
        set_knobs(0, 1, 0, 1, 0, 0, 0, 1);
        req1 = 1; we1 = 1'($urandom); addr1 = ADDR_W'($urandom); wdata1 = DATA_W'($urandom);
        run_cycles(40);
        idx = -1;
        foreach (q_ops[i]) if (idx < 0 && q_ops[i] == 2) idx = i;
        check("refresh_issued", idx >= 0, 1'b1);
        if (idx >= 0) begin
            check("after_refresh_op", (idx + 1 < q_ops.size()) ? q_ops[idx + 1] : 3,
                  we1 ? 1 : 0);
        end
        k_hold = 0;
        run_cycles(20);

        // Refresh miss: core stalls cmd_ready for 40 cycles on the first refresh.
        do_reset(0);
        set_knobs(40, 40, 0, 0, 0, 0, 0, 0);
        run_cycles(70);
        check("miss_sticky", refresh_miss, 1'b1);

        // Backpressure with stray ready/done pulses outside their windows.
        do_reset(0);
        set_knobs(5, 5, 1, 3, 300, 300, 500, 0);
        run_cycles(80);

        // Reset in the middle of ISSUE abandons the transaction.
        do_reset(0);
        set_knobs(8, 8, 0, 0, 0, 0, 0, 0);
        req0 = 1; we0 = 1; addr0 = 24'h123456; wdata0 = 16'hC0DE;
        run_cycles(3);
        check("mid_issue_valid", cmd_valid, 1'b1);
        do_reset(1);
        set_knobs(0, 0, 0, 0, 0, 0, 0, 0);
        run_cycles(10);
        check("post_reset_no_ack", q_grant.size(), 0);

        // Randomised soak.
        do_reset(0);
        set_knobs(0, 4, 0, 4, 400, 400, 200, 0);
        run_cycles(2000);
        set_knobs(0, 20, 0, 6, 700, 700, 300, 0);
        run_cycles(1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
